// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types.
package cpu_types_pkg;
   localparam int WORD_W = 32;
   typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/icache_pkg.sv
// Instruction cache shared types: controller state and per-set frame (valid + tag).
package icache_pkg;
   typedef enum logic {IDLE = 1'b0, FILL = 1'b1} icache_state_t;

   // Widest possible tag (no index/offset bits); instances store zero-extended tags.
   localparam int ICACHE_TAG_MAX = 30;

   typedef struct packed {
      logic                      valid;
      logic [ICACHE_TAG_MAX-1:0] tag;
   } icache_frame_t;
endpackage

// File: rtl/icache_blk.sv
// Direct-mapped, read-only instruction cache with block fill from memory.
// Memory handshake: iREN requests the word at iaddr; a word is accepted on a rising edge where iREN && !iwait.
module icache_blk
   import cpu_types_pkg::*;
   import icache_pkg::*;
#(
   parameter int SETS     = 16,
   parameter int BLKWORDS = 2
) (
   input  logic          CLK,
   input  logic          nRST,
   input  logic          imemREN,
   input  word_t         imemaddr,
   input  logic          pcRST,
   output logic          ihit,
   output word_t         imemload,
   output logic          iREN,
   output word_t         iaddr,
   input  logic          iwait,
   input  word_t         iload,
   output icache_state_t dbg_state
);
   localparam int WOFFW = $clog2(BLKWORDS);
   localparam int IDXW  = $clog2(SETS);
   localparam int CNTW  = (WOFFW > 0) ? WOFFW : 1;
   localparam int TAGW  = 30 - WOFFW - IDXW;
   localparam logic [CNTW-1:0] LAST = CNTW'(BLKWORDS - 1);

   icache_state_t state, next_state;
   icache_frame_t frames [SETS];
   word_t         data   [SETS][BLKWORDS];

   logic [TAGW-1:0] req_tag, fill_tag;
   logic [IDXW-1:0] req_idx, fill_idx;
   logic [CNTW-1:0] req_woff, cnt;
   logic            hit_raw, start_fill, accept, last_word;
   word_t           fill_addr;

   assign req_woff = CNTW'((imemaddr >> 2) & word_t'(BLKWORDS - 1));
   assign req_idx  = IDXW'(imemaddr >> (2 + WOFFW));
   assign req_tag  = TAGW'(imemaddr >> (2 + WOFFW + IDXW));

   assign hit_raw    = frames[req_idx].valid &&
                       (frames[req_idx].tag == ICACHE_TAG_MAX'(req_tag));
   assign start_fill = (state == IDLE) && imemREN && !pcRST && !hit_raw;
   assign accept     = (state == FILL) && !iwait && !pcRST;
   assign last_word  = (cnt == LAST);

   assign fill_addr = (word_t'(fill_tag) << (2 + WOFFW + IDXW)) |
                      (word_t'(fill_idx) << (2 + WOFFW)) |
                      (word_t'(cnt) << 2);

   assign dbg_state = state;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      if (pcRST) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE:    if (imemREN && !hit_raw) next_state = FILL;
            FILL:    if (!iwait && last_word) next_state = IDLE;
            default: next_state = IDLE;
         endcase
      end
   end

   always_comb begin
      ihit     = 1'b0;
      imemload = '0;
      iREN     = 1'b0;
      iaddr    = '0;
      case (state)
         IDLE: begin
            if (imemREN && !pcRST && hit_raw) begin
               ihit     = 1'b1;
               imemload = data[req_idx][req_woff];
            end
         end
         FILL: begin
            iREN  = 1'b1;
            iaddr = fill_addr;
         end
         default: ;
      endcase
   end

   // The target set is invalidated on fill start so a partial block never hits.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         cnt      <= '0;
         fill_tag <= '0;
         fill_idx <= '0;
         for (int i = 0; i < SETS; i++) frames[i] <= '0;
      end else if (pcRST) begin
         cnt <= '0;
         for (int i = 0; i < SETS; i++) frames[i].valid <= 1'b0;
      end else if (start_fill) begin
         fill_tag               <= req_tag;
         fill_idx               <= req_idx;
         cnt                    <= '0;
         frames[req_idx].valid  <= 1'b0;
      end else if (accept) begin
         cnt <= last_word ? '0 : cnt + 1'b1;
         if (last_word) begin
            frames[fill_idx].valid <= 1'b1;
            frames[fill_idx].tag   <= ICACHE_TAG_MAX'(fill_tag);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (accept) data[fill_idx][cnt] <= iload;
   end
endmodule

// File: tb/tb_icache_blk.sv
// Directed bench for icache_blk (SETS=16, BLKWORDS=2) with a hand-driven memory.
module tb_icache_blk;
   import cpu_types_pkg::*;
   import icache_pkg::*;

   logic          CLK = 1'b0;
   logic          nRST, imemREN, pcRST, iwait;
   logic          ihit, iREN;
   word_t         imemaddr, iload, imemload, iaddr;
   icache_state_t dbg_state;

   word_t exp_q[$];
   int    n_checks = 0;
   int    n_fail   = 0;

   icache_blk #(.SETS(16), .BLKWORDS(2)) dut (
      .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
      .pcRST(pcRST), .ihit(ihit), .imemload(imemload), .iREN(iREN),
      .iaddr(iaddr), .iwait(iwait), .iload(iload), .dbg_state(dbg_state)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Called at a negedge while the cache is filling; returns at the negedge after the word is accepted.
   task automatic serve_word(input word_t d, input int waits, input string name);
      word_t a;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s no expected fill address left", name);
         a = '1;
      end else begin
         a = exp_q.pop_front();
      end
      for (int i = 0; i <= waits; i++) begin
         iwait = (i < waits);
         iload = (i < waits) ? 32'hDEAD_BEEF : d;
         #1;
         n_checks++;
         if (iREN !== 1'b1 || iaddr !== a || ihit !== 1'b0) begin
            n_fail++;
            $display("FAIL %s iREN=%0b iaddr=%h ihit=%0b, want iREN=1 iaddr=%h ihit=0",
                     name, iREN, iaddr, ihit, a);
         end
         @(negedge CLK);
      end
      iwait = 1'b1;
      iload = '0;
   endtask

   task automatic test_reset();
      nRST = 1'b0; imemREN = 1'b1; imemaddr = 32'h40; pcRST = 1'b0;
      iwait = 1'b1; iload = '0;
      repeat (3) @(negedge CLK);
      #1;
      n_checks++;
      if (ihit !== 1'b0 || imemload !== 32'h0 || iREN !== 1'b0 || iaddr !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_outputs ihit=%0b imemload=%h iREN=%0b iaddr=%h, want all 0",
                  ihit, imemload, iREN, iaddr);
      end
      n_checks++;
      if (dbg_state !== IDLE) begin
         n_fail++;
         $display("FAIL reset_state state=%0d want IDLE", dbg_state);
      end
      imemREN = 1'b0;
      nRST    = 1'b1;
      @(negedge CLK);
   endtask

   task automatic test_cold_miss();
      imemREN = 1'b1; imemaddr = 32'h40;
      #1;
      n_checks++;
      if (ihit !== 1'b0 || iREN !== 1'b0) begin
         n_fail++;
         $display("FAIL cold_miss_idle ihit=%0b iREN=%0b, want 0 0", ihit, iREN);
      end
      @(negedge CLK);
      exp_q.push_back(32'h40);
      exp_q.push_back(32'h44);
      serve_word(32'hAAAA0001, 2, "cold_w0");
      serve_word(32'hAAAA0002, 2, "cold_w1");
      #1;
      n_checks++;
      if (ihit !== 1'b1 || imemload !== 32'hAAAA0001 || iREN !== 1'b0) begin
         n_fail++;
         $display("FAIL cold_hit ihit=%0b imemload=%h iREN=%0b, want 1 aaaa0001 0",
                  ihit, imemload, iREN);
      end
   endtask

   task automatic test_spatial_hit();
      imemaddr = 32'h44;
      #1;
      n_checks++;
      if (ihit !== 1'b1 || imemload !== 32'hAAAA0002 || iREN !== 1'b0) begin
         n_fail++;
         $display("FAIL spatial_hit ihit=%0b imemload=%h iREN=%0b, want 1 aaaa0002 0",
                  ihit, imemload, iREN);
      end
      @(negedge CLK);
      #1;
      n_checks++;
      if (iREN !== 1'b0 || ihit !== 1'b1) begin
         n_fail++;
         $display("FAIL spatial_stay ihit=%0b iREN=%0b, want 1 0", ihit, iREN);
      end
   endtask

   task automatic test_conflict();
      imemaddr = 32'h440;
      #1;
      n_checks++;
      if (ihit !== 1'b0) begin
         n_fail++;
         $display("FAIL conflict_miss ihit=%0b want 0", ihit);
      end
      @(negedge CLK);
      exp_q.push_back(32'h440);
      exp_q.push_back(32'h444);
      serve_word(32'hBBBB0001, 0, "conflict_w0");
      imemaddr = 32'h100;
      serve_word(32'hBBBB0002, 1, "conflict_w1");
      imemaddr = 32'h440;
      #1;
      n_checks++;
      if (ihit !== 1'b1 || imemload !== 32'hBBBB0001) begin
         n_fail++;
         $display("FAIL conflict_hit0 ihit=%0b imemload=%h, want 1 bbbb0001", ihit, imemload);
      end
      imemaddr = 32'h444;
      #1;
      n_checks++;
      if (ihit !== 1'b1 || imemload !== 32'hBBBB0002) begin
         n_fail++;
         $display("FAIL conflict_hit1 ihit=%0b imemload=%h, want 1 bbbb0002", ihit, imemload);
      end
      imemaddr = 32'h40;
      #1;
      n_checks++;
      if (ihit !== 1'b0) begin
         n_fail++;
         $display("FAIL conflict_evict ihit=%0b want 0", ihit);
      end
      @(negedge CLK);
      exp_q.push_back(32'h40);
      exp_q.push_back(32'h44);
      serve_word(32'hAAAA0011, 0, "refill_w0");
      serve_word(32'hAAAA0012, 0, "refill_w1");
      #1;
      n_checks++;
      if (ihit !== 1'b1 || imemload !== 32'hAAAA0011) begin
         n_fail++;
         $display("FAIL refill_hit ihit=%0b imemload=%h, want 1 aaaa0011", ihit, imemload);
      end
   endtask

   task automatic test_pcrst();
      pcRST = 1'b1;
      #1;
      n_checks++;
      if (ihit !== 1'b0) begin
         n_fail++;
         $display("FAIL pcrst_hit_masked ihit=%0b want 0", ihit);
      end
      @(negedge CLK);
      pcRST = 1'b0;
      #1;
      n_checks++;
      if (ihit !== 1'b0) begin
         n_fail++;
         $display("FAIL pcrst_invalidated ihit=%0b want 0", ihit);
      end
      imemaddr = 32'h80;
      @(negedge CLK);
      exp_q.push_back(32'h80);
      serve_word(32'hCCCC0001, 0, "pcrst_w0");
      pcRST = 1'b1;
      #1;
      n_checks++;
      if (iREN !== 1'b1 || iaddr !== 32'h84) begin
         n_fail++;
         $display("FAIL pcrst_midfill iREN=%0b iaddr=%h, want 1 00000084", iREN, iaddr);
      end
      @(negedge CLK);
      pcRST = 1'b0; imemREN = 1'b0;
      #1;
      n_checks++;
      if (iREN !== 1'b0 || iaddr !== 32'h0 || dbg_state !== IDLE) begin
         n_fail++;
         $display("FAIL pcrst_abort iREN=%0b iaddr=%h state=%0d, want 0 0 IDLE",
                  iREN, iaddr, dbg_state);
      end
      imemREN = 1'b1; imemaddr = 32'h80;
      #1;
      n_checks++;
      if (ihit !== 1'b0) begin
         n_fail++;
         $display("FAIL pcrst_partial_miss ihit=%0b want 0", ihit);
      end
      imemaddr = 32'h40;
      #1;
      n_checks++;
      if (ihit !== 1'b0) begin
         n_fail++;
         $display("FAIL pcrst_old_miss ihit=%0b want 0", ihit);
      end
      imemREN = 1'b0;
      @(negedge CLK);
      #1;
      n_checks++;
      if (iREN !== 1'b0) begin
         n_fail++;
         $display("FAIL no_ren_no_fill iREN=%0b want 0", iREN);
      end
   endtask

   task automatic test_async_reset();
      imemREN = 1'b1; imemaddr = 32'h80;
      @(negedge CLK);
      exp_q.push_back(32'h80);
      exp_q.push_back(32'h84);
      serve_word(32'hDDDD0001, 1, "ar_pre_w0");
      serve_word(32'hDDDD0002, 0, "ar_pre_w1");
      #1;
      n_checks++;
      if (ihit !== 1'b1 || imemload !== 32'hDDDD0001) begin
         n_fail++;
         $display("FAIL ar_pre_hit ihit=%0b imemload=%h, want 1 dddd0001", ihit, imemload);
      end
      imemaddr = 32'h40;
      @(negedge CLK);
      exp_q.push_back(32'h40);
      serve_word(32'hEEEE0001, 0, "ar_mid_w0");
      #2 nRST = 1'b0;
      #1;
      n_checks++;
      if (iREN !== 1'b0 || ihit !== 1'b0 || iaddr !== 32'h0 || dbg_state !== IDLE) begin
         n_fail++;
         $display("FAIL ar_immediate iREN=%0b ihit=%0b iaddr=%h state=%0d, want 0 0 0 IDLE",
                  iREN, ihit, iaddr, dbg_state);
      end
      @(negedge CLK);
      nRST = 1'b1;
      #1;
      n_checks++;
      if (ihit !== 1'b0) begin
         n_fail++;
         $display("FAIL ar_post_miss ihit=%0b want 0", ihit);
      end
      @(negedge CLK);
      exp_q.push_back(32'h40);
      exp_q.push_back(32'h44);
      serve_word(32'hEEEE0011, 0, "ar_post_w0");
      serve_word(32'hEEEE0012, 1, "ar_post_w1");
      #1;
      n_checks++;
      if (ihit !== 1'b1 || imemload !== 32'hEEEE0011) begin
         n_fail++;
         $display("FAIL ar_post_hit ihit=%0b imemload=%h, want 1 eeee0011", ihit, imemload);
      end
      imemaddr = 32'h80;
      #1;
      n_checks++;
      if (ihit !== 1'b0) begin
         n_fail++;
         $display("FAIL ar_cleared ihit=%0b want 0", ihit);
      end
      imemREN = 1'b0;
   endtask

   task automatic test_idle();
      imemREN = 1'b0; imemaddr = 32'h100;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         #1;
         n_checks++;
         if (iREN !== 1'b0 || ihit !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_cycle%0d iREN=%0b ihit=%0b, want 0 0", i, iREN, ihit);
         end
      end
   endtask

   initial begin
      test_reset();
      test_cold_miss();
      test_spatial_hit();
      test_conflict();
      test_pcrst();
      test_async_reset();
      test_idle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/icache_blk.md
ICACHE_BLK -- requirements
Module: icache_blk

Interface
REQ-001 SHALL have parameter SETS, default 16, number of direct-mapped sets (power of 2, >=2).
REQ-002 SHALL have parameter BLKWORDS, default 2, words per block (power of 2, >=1).
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port imemREN  input  1  datapath instruction read request.
REQ-006 SHALL have port imemaddr  input  32  datapath byte address (word_t).
REQ-007 SHALL have port pcRST  input  1  invalidate-all request.
REQ-008 SHALL have port ihit  output  1  requested word valid this cycle.
REQ-009 SHALL have port imemload  output  32  instruction word (word_t).
REQ-010 SHALL have port iREN  output  1  memory read request.
REQ-011 SHALL have port iaddr  output  32  memory byte address, word aligned.
REQ-012 SHALL have port iwait  input  1  memory busy; read data not valid while high.
REQ-013 SHALL have port iload  input  32  memory read data, valid when iREN && !iwait.

Function
REQ-014 SHALL split imemaddr as: [1:0] byte offset (ignored), next log2(BLKWORDS) bits word offset, next log2(SETS) bits index, remaining upper bits tag.
REQ-015 SHALL hold per set: valid bit, tag, BLKWORDS data words.
REQ-016 SHALL implement FSM states IDLE and FILL.
REQ-017 SHALL assert ihit combinationally iff state==IDLE && imemREN && !pcRST && valid[index] && tag match.
REQ-018 SHALL drive imemload = data[index][word offset] when ihit, else 32'h0.
REQ-019 SHALL, in IDLE with imemREN && !pcRST && miss, latch tag and index of imemaddr, clear fill counter to 0, and enter FILL next cycle.
REQ-020 SHALL, in FILL, drive iREN=1 and iaddr = {latched tag, latched index, counter, 2'b00}; in IDLE drive iREN=0, iaddr=32'h0.
REQ-021 SHALL, in FILL when !iwait, write iload into data[latched index][counter] and increment counter.
REQ-022 SHALL, on the accepted word with counter==BLKWORDS-1, write tag, set valid, return to IDLE; the retried access hits the following cycle (miss latency = sum of memory word latencies + 1 cycle).
REQ-023 SHALL keep the latched fill address independent of imemaddr changes during FILL; fill completes for the original block.
REQ-024 SHALL hold valid[index] cleared during FILL so a partially filled block never hits.
REQ-025 SHALL, on pcRST (any state), clear all valid bits at the next edge, abort any fill, return to IDLE, counter 0; ihit=0 that cycle.
REQ-026 SHALL start no fill when imemREN=0.
REQ-027 SHALL wrap counter modulo BLKWORDS; BLKWORDS=1 means a single-word fill.

Reset
REQ-028 SHALL, while nRST=0, force state IDLE, counter 0, all valid bits 0, latched tag/index 0; outputs ihit=0, imemload=0, iREN=0, iaddr=0.
REQ-029 SHALL abort an in-progress fill on reset; tag/data arrays need not be reset.

Structure
REQ-030 SHALL take word_t from cpu_types_pkg; the icache state enum and an icache tag/frame struct parametrised by derived widths SHALL be placed in cpu_types_pkg-compatible shared package icache_pkg.
REQ-031 SHALL be one module with no sub-modules; derived widths computed with $clog2 locally.

Verification (SETS=16, BLKWORDS=2: woff=bit2, index=[6:3], tag=[31:7])
REQ-032 Cold miss: reset, imemREN=1, imemaddr=0x40, iwait high 2 cycles per word, iload=0xAAAA0001 then 0xAAAA0002 -> iaddr 0x40 then 0x44, ihit=1 with imemload=0xAAAA0001 one cycle after second word.
REQ-033 Spatial hit: after REQ-032, imemaddr=0x44 -> ihit=1 same cycle, imemload=0xAAAA0002, iREN stays 0.
REQ-034 Conflict: after REQ-032, imemaddr=0x440 (index 8, new tag) -> miss, fill 0x440/0x444; then 0x40 misses again.
REQ-035 pcRST mid-fill: assert pcRST after first word of 0x80 fill -> next cycle IDLE, iREN=0; 0x40 and 0x80 both miss afterwards.
REQ-036 Async reset mid-fill: drop nRST between edges -> iREN=0, ihit=0 immediately; after release 0x40 misses.
REQ-037 Idle: imemREN=0, imemaddr=0x100 for 10 cycles -> iREN=0, ihit=0 throughout.
